// File: rtl/pipe_gap_seq_if.sv
// pipe_gap_seq_if: request/response and edge-bus bundle between the game
// controller / renderer side (master) and the gap generator (slave).
interface pipe_gap_seq_if #(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned Y_W       = 10
);
  localparam int unsigned SW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic                     restart;
  logic                     advance;
  logic                     ready;
  logic                     done;
  logic [SW-1:0]            slot;
  logic [NUM_PIPES*Y_W-1:0] y_edge_t;
  logic [NUM_PIPES*Y_W-1:0] y_edge_b;

  modport master (
    output restart, advance,
    input  ready, done, slot, y_edge_t, y_edge_b
  );

  modport slave (
    input  restart, advance,
    output ready, done, slot, y_edge_t, y_edge_b
  );
endinterface

// File: rtl/pipe_gap_seq.sv
// pipe_gap_seq: holds NUM_PIPES top/bottom gap edge pairs and refreshes one
// slot per accepted request, round-robin, with a gap position drawn from a
// free-running 16-bit LFSR through a reject-and-retry range sampler.
// Optional feature macro: PIPE_GAP_SHRINK_EN -- gap shrinks by 2 on every
// 8th Done, saturating at GAP_MIN.
module pipe_gap_seq #(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned Y_W       = 10,
  parameter int unsigned Y_MIN     = 40,
  parameter int unsigned Y_MAX     = 440,
  parameter int unsigned GAP       = 100,
  parameter int unsigned GAP_MIN   = 60,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input logic           clk,
  input logic           reset_n,
  pipe_gap_seq_if.slave bus
);

  localparam int unsigned SW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int unsigned CW = Y_W + 1;
`ifdef PIPE_GAP_SHRINK_EN
  localparam int unsigned RANGE_MAX = Y_MAX - GAP_MIN - Y_MIN;
`else
  localparam int unsigned RANGE_MAX = Y_MAX - GAP - Y_MIN;
`endif
  localparam int unsigned RW       = $clog2(RANGE_MAX + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [SW-1:0] LAST   = SW'(NUM_PIPES - 1);

  // Reject parameter sets that would make edges wrap or the gap floor invalid.
  if (NUM_PIPES < 2 || GAP_MIN > GAP || (Y_MIN + GAP) > Y_MAX ||
      (Y_MAX >> Y_W) != 0) begin : g_param_check
    $error("pipe_gap_seq: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_GEN  = 2'd2
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic            fb;
  logic [RW-1:0]   cand;
  logic [Y_W-1:0]  gap;
  logic [CW-1:0]   range_lim;
  logic            accept;
  logic [Y_W-1:0]  top_val;
  logic [Y_W-1:0]  bot_val;
  logic            wr;
  logic            gen_wr;
  logic [SW-1:0]   head;
  logic [SW-1:0]   next_head;
  logic [SW-1:0]   slot_q;
  logic            ready_q;
  logic            done_q;
  logic [Y_W-1:0]  edge_t [NUM_PIPES];
  logic [Y_W-1:0]  edge_b [NUM_PIPES];

  // Candidate sampling, accept test and edge arithmetic (mod 2^Y_W).
  always_comb begin
    fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    cand      = lfsr[RW-1:0];
    range_lim = CW'(Y_MAX) - CW'(gap) - CW'(Y_MIN);
    accept    = (CW'(cand) <= range_lim);
    top_val   = Y_W'(Y_MIN) + Y_W'(cand);
    bot_val   = top_val + gap;
    next_head = (head == LAST) ? '0 : head + SW'(1);
    wr        = accept && !bus.restart && (state == S_INIT || state == S_GEN);
    gen_wr    = accept && !bus.restart && (state == S_GEN);
  end

  // Free-running LFSR; only reset reseeds it, Restart does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

  // Control FSM: init fill, idle wait, one-slot generate; Restart overrides.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_INIT;
      head    <= '0;
      slot_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.restart) begin
        state   <= S_INIT;
        head    <= '0;
        slot_q  <= '0;
        ready_q <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            if (accept) begin
              head <= next_head;
              if (head == LAST) begin
                state   <= S_IDLE;
                ready_q <= 1'b1;
              end
            end
          end
          S_IDLE: begin
            if (bus.advance) begin
              state   <= S_GEN;
              ready_q <= 1'b0;
            end
          end
          S_GEN: begin
            if (accept) begin
              slot_q  <= head;
              head    <= next_head;
              done_q  <= 1'b1;
              state   <= S_IDLE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state   <= S_INIT;
            head    <= '0;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Edge storage: only the head slot is written on an accepted candidate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        edge_t[i] <= Y_W'(Y_MIN);
        edge_b[i] <= Y_W'(Y_MIN + GAP);
      end
    end else if (bus.restart) begin
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        edge_t[i] <= Y_W'(Y_MIN);
        edge_b[i] <= Y_W'(Y_MIN + GAP);
      end
    end else if (wr) begin
      for (int unsigned i = 0; i < NUM_PIPES; i++) begin
        if (head == SW'(i)) begin
          edge_t[i] <= top_val;
          edge_b[i] <= bot_val;
        end
      end
    end
  end

`ifdef PIPE_GAP_SHRINK_EN
  logic [2:0] done_cnt;

  // Gap shrink: every 8th Done narrows the gap by 2 down to GAP_MIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap      <= Y_W'(GAP);
      done_cnt <= '0;
    end else if (bus.restart) begin
      gap      <= Y_W'(GAP);
      done_cnt <= '0;
    end else if (gen_wr) begin
      done_cnt <= done_cnt + 3'd1;
      if (done_cnt == 3'd7) begin
        gap <= (gap >= Y_W'(GAP_MIN + 2)) ? gap - Y_W'(2) : Y_W'(GAP_MIN);
      end
    end
  end
`else
  logic unused_gen_wr;
  assign unused_gen_wr = gen_wr;
  assign gap           = Y_W'(GAP);
`endif

  // Output packing: slot i occupies [i*Y_W +: Y_W].
  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
    assign bus.y_edge_t[g*Y_W +: Y_W] = edge_t[g];
    assign bus.y_edge_b[g*Y_W +: Y_W] = edge_b[g];
  end

  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.slot  = slot_q;

endmodule

// File: tb/tb_pipe_gap_seq.sv
// tb_pipe_gap_seq: directed self-checking bench for pipe_gap_seq.
module tb_pipe_gap_seq;

  localparam int NP = 4;
  localparam int YW = 10;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  logic [YW-1:0] snap_t [NP];
  logic [YW-1:0] snap_b [NP];

  int h_done, h_entry, h_bad_slot, h_init_done, h_exp_slot;
  bit h_seen_ready;

  pipe_gap_seq_if #(.NUM_PIPES(NP), .Y_W(YW)) bus ();

  pipe_gap_seq #(
    .NUM_PIPES(NP), .Y_W(YW), .Y_MIN(40), .Y_MAX(440),
    .GAP(100), .GAP_MIN(60), .SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [YW-1:0] top_of(input int i);
    return bus.y_edge_t[i*YW +: YW];
  endfunction

  function automatic logic [YW-1:0] bot_of(input int i);
    return bus.y_edge_b[i*YW +: YW];
  endfunction

  task automatic snapshot();
    for (int i = 0; i < NP; i++) begin
      snap_t[i] = top_of(i);
      snap_b[i] = bot_of(i);
    end
  endtask

  task automatic wait_ready(input int max_cyc, output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (!bus.ready && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (bus.done) dones++;
    end
  endtask

  // One Advance pulse from IDLE; returns Done latency in edges after edge k.
  task automatic do_advance(output int lat, output bit got, output bit early);
    got = 0;
    lat = 0;
    @(negedge clk);
    bus.advance = 1'b1;
    @(negedge clk);
    bus.advance = 1'b0;
    early = bus.done;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        lat = c;
        break;
      end
    end
  endtask

  task automatic note_done();
    if (bus.done) begin
      h_done++;
      if (!h_seen_ready) h_init_done++;
      if (bus.slot !== 2'(h_exp_slot)) h_bad_slot++;
      h_exp_slot = (h_exp_slot + 1) % NP;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.restart = 1'b0;
    bus.advance = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%0b exp=0", bus.ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL reset_slot got=%0d exp=0", bus.slot); end
    for (int i = 0; i < NP; i++) begin
      n_cmp++; if (top_of(i) !== 10'd40) begin n_err++; $display("FAIL reset_top[%0d] got=%0d exp=40", i, top_of(i)); end
      n_cmp++; if (bot_of(i) !== 10'd140) begin n_err++; $display("FAIL reset_bot[%0d] got=%0d exp=140", i, bot_of(i)); end
    end
  endtask

  task automatic test_init_fill();
    int cyc, dones;
    bit ok;
    reset_n = 1'b1;
    wait_ready(256, cyc, dones);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL init_ready got=%0b exp=1 after %0d cycles", bus.ready, cyc); end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL init_done_pulses got=%0d exp=0", dones); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL init_slot got=%0d exp=0", bus.slot); end
    // First candidate is SEED[8:0] = 225, accepted on the first edge.
    n_cmp++; if (top_of(0) !== 10'd265) begin n_err++; $display("FAIL init_seed_top got=%0d exp=265", top_of(0)); end
    n_cmp++; if (bot_of(0) !== 10'd365) begin n_err++; $display("FAIL init_seed_bot got=%0d exp=365", bot_of(0)); end
    for (int i = 0; i < NP; i++) begin
      ok = (top_of(i) >= 10'd40) && (top_of(i) <= 10'd340);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL init_top_range[%0d] got=%0d exp=40..340", i, top_of(i)); end
      n_cmp++; if (bot_of(i) !== top_of(i) + 10'd100) begin n_err++; $display("FAIL init_bot[%0d] got=%0d exp=%0d", i, bot_of(i), top_of(i) + 10'd100); end
    end
  endtask

  task automatic test_advance_wrap();
    int lat;
    bit got, early, ok;
    for (int n = 0; n < 5; n++) begin
      snapshot();
      do_advance(lat, got, early);
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL adv%0d_done_timeout got=%0b exp=1", n, got); end
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL adv%0d_early_done got=%0b exp=0", n, early); end
      n_cmp++; if (bus.slot !== 2'(n % NP)) begin n_err++; $display("FAIL adv%0d_slot got=%0d exp=%0d", n, bus.slot, n % NP); end
      n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL adv%0d_ready_with_done got=%0b exp=1", n, bus.ready); end
      for (int i = 0; i < NP; i++) begin
        if (i == n % NP) begin
          ok = (top_of(i) >= 10'd40) && (top_of(i) <= 10'd340) && (bot_of(i) == top_of(i) + 10'd100);
          n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL adv%0d_written[%0d] got=%0d/%0d exp=top 40..340 bot=top+100", n, i, top_of(i), bot_of(i)); end
        end else begin
          ok = (top_of(i) == snap_t[i]) && (bot_of(i) == snap_b[i]);
          n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL adv%0d_untouched[%0d] got=%0d/%0d exp=%0d/%0d", n, i, top_of(i), bot_of(i), snap_t[i], snap_b[i]); end
        end
      end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL adv%0d_done_width got=%0b exp=0", n, bus.done); end
    end
  endtask

  task automatic test_advance_held();
    bit ok;
    h_done = 0; h_entry = 0; h_bad_slot = 0; h_init_done = 0; h_exp_slot = 0; h_seen_ready = 0;
    @(negedge clk);
    bus.restart = 1'b1;
    bus.advance = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL held_restart_wins got=%0b exp=0", bus.ready); end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      note_done();
      if (bus.ready) begin
        h_entry++;
        h_seen_ready = 1;
      end
    end
    @(negedge clk);
    note_done();
    bus.advance = 1'b0;
    for (int c = 0; c < 64 && !bus.ready; c++) begin
      @(negedge clk);
      note_done();
    end
    ok = (h_entry > 4);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL held_entries got=%0d exp=>4", h_entry); end
    n_cmp++; if (h_done !== h_entry) begin n_err++; $display("FAIL held_done_count got=%0d exp=%0d", h_done, h_entry); end
    n_cmp++; if (h_bad_slot !== 0) begin n_err++; $display("FAIL held_slot_order got=%0d exp=0 bad", h_bad_slot); end
    n_cmp++; if (h_init_done !== 0) begin n_err++; $display("FAIL held_init_done got=%0d exp=0", h_init_done); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL held_drain_ready got=%0b exp=1", bus.ready); end
  endtask

  task automatic test_restart_gen();
    int lat, cyc, dones;
    bit got, early, ok;
    do_advance(lat, got, early);
    if (bus.slot == 2'd0) do_advance(lat, got, early);
    @(negedge clk);
    bus.advance = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rst_gen_entered got=%0b exp=0", bus.ready); end
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    bus.advance = 1'b0;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rst_gen_ready got=%0b exp=0", bus.ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_gen_done got=%0b exp=0", bus.done); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL rst_gen_slot got=%0d exp=0", bus.slot); end
    for (int i = 0; i < NP; i++) begin
      ok = (top_of(i) == 10'd40) && (bot_of(i) == 10'd140);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_gen_edges[%0d] got=%0d/%0d exp=40/140", i, top_of(i), bot_of(i)); end
    end
    wait_ready(256, cyc, dones);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rst_refill_ready got=%0b exp=1", bus.ready); end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rst_refill_done got=%0d exp=0", dones); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL rst_refill_slot got=%0d exp=0", bus.slot); end
    for (int i = 0; i < NP; i++) begin
      ok = (top_of(i) >= 10'd40) && (top_of(i) <= 10'd340) && (bot_of(i) == top_of(i) + 10'd100);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rst_refill_edges[%0d] got=%0d/%0d exp=top 40..340 bot=top+100", i, top_of(i), bot_of(i)); end
    end
  endtask

  task automatic test_async_reset();
    int lat, cyc, dones;
    bit got, early, ok;
    do_advance(lat, got, early);
    if (bus.slot == 2'd0) do_advance(lat, got, early);
    @(negedge clk);
    bus.advance = 1'b1;
    @(negedge clk);
    bus.advance = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL async_ready got=%0b exp=0", bus.ready); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL async_done got=%0b exp=0", bus.done); end
    n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL async_slot got=%0d exp=0", bus.slot); end
    for (int i = 0; i < NP; i++) begin
      ok = (top_of(i) == 10'd40) && (bot_of(i) == 10'd140);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL async_edges[%0d] got=%0d/%0d exp=40/140", i, top_of(i), bot_of(i)); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(256, cyc, dones);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL async_refill_ready got=%0b exp=1", bus.ready); end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL async_refill_done got=%0d exp=0", dones); end
    n_cmp++; if (top_of(0) !== 10'd265) begin n_err++; $display("FAIL async_reseed_top got=%0d exp=265", top_of(0)); end
  endtask

  task automatic test_gap_shrink();
    int lat, s, diff, eg;
    bit got, early, ok;
    for (int d = 1; d <= 176; d++) begin
      do_advance(lat, got, early);
      s = int'(bus.slot);
`ifdef PIPE_GAP_SHRINK_EN
      eg = 100 - 2 * ((d - 1) / 8);
      if (eg < 60) eg = 60;
`else
      eg = 100;
`endif
      n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL gap_done%0d_timeout got=%0b exp=1", d, got); end
      diff = int'(bot_of(s)) - int'(top_of(s));
      n_cmp++; if (diff !== eg) begin n_err++; $display("FAIL gap_done%0d got=%0d exp=%0d", d, diff, eg); end
      ok = (top_of(s) >= 10'd40) && (bot_of(s) <= 10'd440);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL gap_range%0d got=%0d/%0d exp=top>=40 bot<=440", d, top_of(s), bot_of(s)); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_init_fill();
    test_advance_wrap();
    test_advance_held();
    test_restart_gen();
    test_async_reset();
    test_gap_shrink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
